// File: rtl/song_pkg.sv
// Shared types and score-entry layout for the song sequencer.
package song_pkg;

  // Player states; IDLE must stay the all-zero encoding so reset lands there.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_CHECK = 2'd2,
    S_PLAY  = 2'd3
  } state_t;

  // A score entry is {dur, notes}: the notes sit in the LSBs starting here,
  // and the duration fills the bits above them.
  localparam int NOTES_LSB = 0;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 250000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Counter runs 0..TICK_DIV-1 while enabled; clr wins so each step starts aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     cnt <= '0;
    else if (clr)     cnt <= '0;
    else if (en)      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/song_sequencer.sv
// Score player: walks a writable score RAM and drives the tone-generator enables.
module song_sequencer
  import song_pkg::*;
#(
  parameter int NUM_NOTES = 8,
  parameter int ADDR_W    = 4,
  parameter int DUR_W     = 8,
  parameter int TICK_DIV  = 250000,
  parameter int GAP_TICKS = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 loop,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [NUM_NOTES-1:0] wr_notes,
  input  logic [DUR_W-1:0]     wr_dur,
  output logic [NUM_NOTES-1:0] note_en,
  output logic                 busy,
  output logic [ADDR_W-1:0]    step_idx,
  output logic                 done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int EW    = NUM_NOTES + DUR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [DUR_W:0]    GAP       = (DUR_W+1)'(GAP_TICKS);

  state_t state, state_nxt;

  logic [EW-1:0]        mem [DEPTH];
  logic [EW-1:0]        rd_q;
  logic [NUM_NOTES-1:0] rd_notes;
  logic [DUR_W-1:0]     rd_dur;

  logic [ADDR_W-1:0]    addr, addr_nxt;
  logic [NUM_NOTES-1:0] notes_q;
  logic [DUR_W-1:0]     dur_q;
  logic [DUR_W-1:0]     ticks_el;
  logic                 done_nxt;
  logic                 latch;
  logic                 step_end;
  logic                 end_song;
  logic                 tick;

  // Score RAM: no reset, read-before-write on a same-address collision.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {wr_dur, wr_notes};
    rd_q <= mem[addr];
  end

  assign rd_notes = rd_q[NOTES_LSB +: NUM_NOTES];
  assign rd_dur   = rd_q[EW-1 -: DUR_W];

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state == S_PLAY),
    .clr     (state == S_CHECK),
    .tick    (tick)
  );

  assign step_end = tick && (({1'b0, ticks_el} + 1'b1) == {1'b0, dur_q});

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next state, next address and done; stop overrides start, start overrides sequencing.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    done_nxt  = 1'b0;
    latch     = 1'b0;
    end_song  = 1'b0;
    case (state)
      S_IDLE:  ;
      S_FETCH: state_nxt = S_CHECK;
      S_CHECK: begin
        if (rd_dur == '0) end_song = 1'b1;
        else begin
          latch     = 1'b1;
          state_nxt = S_PLAY;
        end
      end
      S_PLAY: begin
        if (step_end) begin
          if (addr == LAST_ADDR) end_song = 1'b1;
          else begin
            addr_nxt  = addr + 1'b1;
            state_nxt = S_FETCH;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (end_song) begin
      if (loop) begin
        addr_nxt  = '0;
        state_nxt = S_FETCH;
      end else begin
        state_nxt = S_IDLE;
        done_nxt  = 1'b1;
      end
    end
    if (start) begin
      addr_nxt  = '0;
      state_nxt = S_FETCH;
      done_nxt  = 1'b0;
    end
    if (stop) begin
      state_nxt = S_IDLE;
      done_nxt  = 1'b0;
    end
  end

  // Datapath: address, latched step, elapsed-tick counter and done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr     <= '0;
      step_idx <= '0;
      notes_q  <= '0;
      dur_q    <= '0;
      ticks_el <= '0;
      done     <= 1'b0;
    end else begin
      addr <= addr_nxt;
      done <= done_nxt;
      if (latch) begin
        notes_q  <= rd_notes;
        dur_q    <= rd_dur;
        step_idx <= addr;
        ticks_el <= '0;
      end else if (state == S_PLAY && tick) begin
        ticks_el <= ticks_el + 1'b1;
      end
    end
  end

  // Notes sound for the first dur-GAP ticks of a step; the tail is the re-strike gap.
  assign note_en = (state == S_PLAY && (({1'b0, ticks_el} + GAP) < {1'b0, dur_q}))
                   ? notes_q : '0;
  assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with TICK_DIV=4 (gap 1 and gap 0 instances).
module tb_song_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, loop = 1'b0, wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_notes = '0, wr_dur = '0;

  logic [7:0] note_en, note_en0;
  logic       busy, busy0, done, done0;
  logic [3:0] step_idx, step_idx0;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  song_sequencer #(.NUM_NOTES(8), .ADDR_W(4), .DUR_W(8), .TICK_DIV(4), .GAP_TICKS(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .loop(loop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_notes(wr_notes), .wr_dur(wr_dur),
    .note_en(note_en), .busy(busy), .step_idx(step_idx), .done(done));

  song_sequencer #(.NUM_NOTES(8), .ADDR_W(4), .DUR_W(8), .TICK_DIV(4), .GAP_TICKS(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .loop(loop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_notes(wr_notes), .wr_dur(wr_dur),
    .note_en(note_en0), .busy(busy0), .step_idx(step_idx0), .done(done0));

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input logic [7:0] n, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_notes = n; wr_dur = d;
    adv();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    adv();
    start = 1'b0;
  endtask

  task automatic push(input logic [7:0] v, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(v);
  endtask

  task automatic load_basic();
    wr(0, 8'h15, 8'd3);
    wr(1, 8'h80, 8'd2);
    wr(2, 8'h00, 8'd0);
  endtask

  task automatic test_reset();
    #3;
    checks++; if (note_en !== 8'h00) begin errors++; $display("FAIL rst_note: got %h want 00", note_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (step_idx !== 4'd0) begin errors++; $display("FAIL rst_step: got %0d want 0", step_idx); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    adv();
  endtask

  task automatic test_basic();
    int n_done = 0;
    load_basic();
    exp_q.delete();
    push(8'h00, 2); push(8'h15, 8); push(8'h00, 4); push(8'h00, 2);
    push(8'h80, 4); push(8'h00, 4); push(8'h00, 2);
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (note_en !== exp_q[i]) begin errors++; $display("FAIL basic_note[%0d]: got %h want %h", i, note_en, exp_q[i]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy[%0d]: got %b want 1", i, busy); end
      if (done === 1'b1) n_done++;
      if (i == 2) begin checks++; if (step_idx !== 4'd0) begin errors++; $display("FAIL basic_step0: got %0d want 0", step_idx); end end
      if (i == 16) begin checks++; if (step_idx !== 4'd1) begin errors++; $display("FAIL basic_step1: got %0d want 1", step_idx); end end
      adv();
    end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL basic_early_done: got %0d want 0", n_done); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_end: got done=%b busy=%b want 1 0", done, busy); end
    adv();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b want 0", done); end
  endtask

  task automatic test_loop();
    loop = 1'b1;
    exp_q.delete();
    push(8'h00, 2); push(8'h15, 8); push(8'h00, 4); push(8'h00, 2);
    push(8'h80, 4); push(8'h00, 4); push(8'h00, 4); push(8'h15, 8);
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (note_en !== exp_q[i]) begin errors++; $display("FAIL loop_note[%0d]: got %h want %h", i, note_en, exp_q[i]); end
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL loop_state[%0d]: got busy=%b done=%b want 1 0", i, busy, done); end
      adv();
    end
    stop = 1'b1; adv(); stop = 1'b0;
    loop = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL loop_stop: got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_no_wrap();
    for (int a = 0; a < 16; a++) wr(a, 8'hFF, 8'd1);
    pulse_start();
    for (int i = 0; i < 96; i++) begin
      checks++; if (note_en !== 8'h00 || busy !== 1'b1) begin errors++; $display("FAIL wrap_play[%0d]: got note=%h busy=%b want 00 1", i, note_en, busy); end
      if ((i % 6) >= 2) begin
        checks++; if (step_idx !== 4'(i / 6)) begin errors++; $display("FAIL wrap_step[%0d]: got %0d want %0d", i, step_idx, i / 6); end
      end
      adv();
    end
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL wrap_end: got busy=%b done=%b want 0 1", busy, done); end
    checks++; if (step_idx !== 4'd15) begin errors++; $display("FAIL wrap_last: got %0d want 15", step_idx); end
    adv();
  endtask

  task automatic test_stop_restart();
    load_basic();
    pulse_start();
    repeat (4) adv();
    checks++; if (note_en !== 8'h15) begin errors++; $display("FAIL stop_pre: got %h want 15", note_en); end
    stop = 1'b1; adv(); stop = 1'b0;
    checks++; if (note_en !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL stop_post: got note=%h busy=%b done=%b want 00 0 0", note_en, busy, done); end
    adv();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stop_quiet: got done=%b busy=%b want 0 0", done, busy); end
    start = 1'b1; stop = 1'b1; adv(); start = 1'b0; stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL startstop: got busy=%b want 0", busy); end
    adv();
    checks++; if (busy !== 1'b0 || note_en !== 8'h00) begin errors++; $display("FAIL startstop_hold: got busy=%b note=%h want 0 00", busy, note_en); end
    pulse_start();
    repeat (17) adv();
    checks++; if (note_en !== 8'h80 || step_idx !== 4'd1) begin errors++; $display("FAIL restart_pre: got note=%h step=%0d want 80 1", note_en, step_idx); end
    pulse_start();
    checks++; if (busy !== 1'b1 || note_en !== 8'h00) begin errors++; $display("FAIL restart_fetch: got busy=%b note=%h want 1 00", busy, note_en); end
    adv(); adv();
    checks++; if (note_en !== 8'h15 || step_idx !== 4'd0) begin errors++; $display("FAIL restart_play: got note=%h step=%0d want 15 0", note_en, step_idx); end
    stop = 1'b1; adv(); stop = 1'b0;
  endtask

  task automatic test_async_reset();
    pulse_start();
    repeat (17) adv();
    checks++; if (note_en !== 8'h80 || step_idx !== 4'd1) begin errors++; $display("FAIL areset_pre: got note=%h step=%0d want 80 1", note_en, step_idx); end
    reset_n = 1'b0;
    #1;
    checks++; if (note_en !== 8'h00 || step_idx !== 4'd0) begin errors++; $display("FAIL areset_now: got note=%h step=%0d want 00 0", note_en, step_idx); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL areset_ctl: got busy=%b done=%b want 0 0", busy, done); end
    adv();
    reset_n = 1'b1;
    adv();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_idle: got busy=%b want 0", busy); end
    pulse_start();
    adv(); adv();
    checks++; if (note_en !== 8'h15) begin errors++; $display("FAIL areset_replay0: got %h want 15", note_en); end
    repeat (14) adv();
    checks++; if (note_en !== 8'h80 || step_idx !== 4'd1) begin errors++; $display("FAIL areset_replay1: got note=%h step=%0d want 80 1", note_en, step_idx); end
    stop = 1'b1; adv(); stop = 1'b0;
  endtask

  task automatic test_no_gap();
    wr(0, 8'h01, 8'd2);
    wr(1, 8'h01, 8'd2);
    wr(2, 8'h00, 8'd0);
    exp_q.delete();
    push(8'h00, 2); push(8'h01, 8); push(8'h00, 2); push(8'h01, 8); push(8'h00, 2);
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (note_en0 !== exp_q[i] || busy0 !== 1'b1) begin errors++; $display("FAIL nogap[%0d]: got note=%h busy=%b want %h 1", i, note_en0, busy0, exp_q[i]); end
      adv();
    end
    checks++; if (done0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL nogap_end: got done=%b busy=%b want 1 0", done0, busy0); end
    adv();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_loop();
    test_no_wrap();
    test_stop_restart();
    test_async_reset();
    test_no_gap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
